sbus_frame_decoder_param: RTL
=============================

// Module: sbus_frame_decoder_param
// PURPOSE
//   Parametrised packed-channel frame decoder (S-Bus family) fed by the UART RX byte stream.
//   Frame: START_BYTE, payload of NUM_CH channels x CH_WIDTH bits packed into
//   NB = ceil(NUM_CH*CH_WIDTH/8) bytes, one flags byte, END_BYTE.
//   Adds selectable bit order, inter-byte gap resync, failsafe/frame-lost decode,
//   self-recovering errors and an error counter; feeds the flight-control RC input path.
// PARAMETERS
//   NUM_CH              16        channel count (1..32)
//   CH_WIDTH            11        bits per channel (1..16)
//   START_BYTE          8'hF0     frame header
//   END_BYTE            8'h00     frame trailer
//   LSB_FIRST           1         1: channel LSB = stream bit 8k+b; 0: MSB-first packing
//   BYTE_GAP_TICKS      5000      max clk cycles between bytes inside a frame; 0 disables
//   FRAME_TIMEOUT_TICKS 10000000  clk cycles without a valid frame before timeout
// PORTS
//   clk_i            in   1                  system clock
//   rst_ni           in   1                  async active-low reset
//   uart_i           in   8                  received byte, valid when rdy_i
//   rdy_i            in   1                  1-cycle byte strobe from UART RX
//   err_i            in   1                  UART framing/parity error strobe
//   channels_o       out  NUM_CH*CH_WIDTH    channel c at [c*CH_WIDTH +: CH_WIDTH]
//   flags_o          out  8                  flags byte of last valid frame
//   failsafe_o       out  1                  flags_o[3]
//   frame_lost_o     out  1                  flags_o[2]
//   frame_rdy_o      out  1                  1-cycle pulse: new valid frame on outputs
//   frame_err_o      out  1                  1-cycle pulse: frame discarded
//   frame_timeout_o  out  1                  level: no valid frame for FRAME_TIMEOUT_TICKS
//   err_cnt_o        out  16                 discarded-frame count, saturating
// BEHAVIOUR
//   Reset: all outputs 0, state HUNT, counters 0; reset mid-frame discards partial data.
//   States: HUNT -(rdy_i & uart_i==START_BYTE)-> DATA; DATA -(NB bytes)-> FLAGS;
//     FLAGS -(1 byte, held in shadow)-> END; END -(uart_i==END_BYTE)-> HUNT + commit,
//     END -(other byte)-> HUNT + error. Non-start bytes in HUNT ignored, not counted.
//   START_BYTE inside DATA/FLAGS is payload, never a resync.
//   Payload gathered in shadow register; channels_o/flags_o update atomically on commit,
//     frame_rdy_o pulses the cycle after the END byte strobe (latency 1 clk).
//   Packing: stream bit s of byte k bit b: LSB_FIRST=1 s=8k+b, channel c bit i = s=c*W+i;
//     LSB_FIRST=0 s=8k+(7-b), channel c bit (W-1-i) = s=c*W+i. Pad bits of last byte ignored.
//   Error (err_i, bad END byte, gap exceeded in DATA/FLAGS/END): discard shadow, go HUNT,
//     frame_err_o 1-cycle pulse, err_cnt_o +1 saturating at 16'hFFFF; outputs keep last frame.
//     No sticky error state: decoder resyncs on next START_BYTE.
//   Gap counter: cleared on every rdy_i, counts in DATA/FLAGS/END; error when == BYTE_GAP_TICKS.
//   Frame timer: cleared on commit, saturating increment otherwise; frame_timeout_o=1 while
//     timer >= FRAME_TIMEOUT_TICKS, cleared on same cycle frame_rdy_o rises.
//   Simultaneous err_i & rdy_i: err_i wins, byte dropped. Gap expiry and rdy_i same cycle:
//     byte accepted (rdy_i wins). Commit and timeout same cycle: commit wins.
//   Byte counter width $clog2(NB+2); wrap impossible as FSM bounds it.
// TESTING
//   T1 defaults: F0, byte0=FF, 21x00, flags 00, 00 -> ch0=0x0FF, ch1..15=0, frame_rdy_o one
//     pulse, err_cnt_o=0.
//   T2 defaults: F0, byte1=04, byte2=20, others 00, flags 0C, 00 -> ch0=0x400, ch1=0x400,
//     failsafe_o=1, frame_lost_o=1, flags_o=0x0C.
//   T3 LSB_FIRST=0, NUM_CH=2, CH_WIDTH=12: F0,AB,CD,EF,55,00 -> ch0=0xABC, ch1=0xDEF,
//     flags_o=0x55.
//   T4 valid frame, then frame with END byte 0x01 -> frame_err_o pulse, err_cnt_o=1,
//     channels unchanged; next valid frame decodes normally.
//   T5 BYTE_GAP_TICKS=100: stall 100 clks after byte 5 -> frame_err_o pulse, HUNT; resumed
//     bytes ignored until next F0.
//   T6 FRAME_TIMEOUT_TICKS=1000, idle -> frame_timeout_o=1 at cycle 1000; valid frame ->
//     cleared with frame_rdy_o; err_i with rdy_i mid-frame -> error, byte dropped.

Source files
------------

// File: rtl/sbus_frame_decoder_param.sv
// S-Bus style packed-channel frame decoder driven by a UART RX byte stream.
// Frames are gathered in a shadow register and committed atomically on a valid END byte.
module sbus_frame_decoder_param #(
  parameter int unsigned NUM_CH              = 16,
  parameter int unsigned CH_WIDTH            = 11,
  parameter logic [7:0]  START_BYTE          = 8'hF0,
  parameter logic [7:0]  END_BYTE            = 8'h00,
  parameter bit          LSB_FIRST           = 1'b1,
  parameter int unsigned BYTE_GAP_TICKS      = 5000,
  parameter int unsigned FRAME_TIMEOUT_TICKS = 10000000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [7:0]                   uart_i,
  input  logic                         rdy_i,
  input  logic                         err_i,
  output logic [NUM_CH*CH_WIDTH-1:0]   channels_o,
  output logic [7:0]                   flags_o,
  output logic                         failsafe_o,
  output logic                         frame_lost_o,
  output logic                         frame_rdy_o,
  output logic                         frame_err_o,
  output logic                         frame_timeout_o,
  output logic [15:0]                  err_cnt_o
);

  localparam int unsigned PW = NUM_CH * CH_WIDTH;
  localparam int unsigned NB = (PW + 7) / 8;
  localparam int unsigned BW = $clog2(NB + 2);
  localparam int unsigned GW = (BYTE_GAP_TICKS > 1) ? $clog2(BYTE_GAP_TICKS + 1) : 1;
  localparam int unsigned TW = (FRAME_TIMEOUT_TICKS > 1) ? $clog2(FRAME_TIMEOUT_TICKS + 1) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(BYTE_GAP_TICKS);
  localparam logic [TW-1:0] TMAX    = TW'(FRAME_TIMEOUT_TICKS);
  localparam logic [BW-1:0] LAST_B  = BW'(NB - 1);

  typedef enum logic [1:0] {ST_HUNT, ST_DATA, ST_FLAGS, ST_END} state_e;

  state_e          state_q;
  logic [PW-1:0]   shadow_q, shadow_d;
  logic [7:0]      flags_sh_q;
  logic [BW-1:0]   byte_cnt_q;
  logic [GW-1:0]   gap_q, gap_d, gap_inc;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   channels_q, chan_dec;
  logic [7:0]      flags_q;
  logic            frame_rdy_q, frame_err_q, timeout_q;
  logic [15:0]     err_cnt_q;

  logic [7:0]      byte_in;
  logic            byte_ok, in_frame, gap_exp, bad_end, frame_error, commit;

  always_comb begin
    byte_in = uart_i;
    if (!LSB_FIRST) begin
      for (int unsigned b = 0; b < 8; b++) byte_in[b] = uart_i[7-b];
    end
  end

  // err_i on the same cycle as rdy_i drops the byte; rdy_i beats a gap expiry.
  always_comb begin
    byte_ok     = rdy_i && !err_i;
    in_frame    = (state_q != ST_HUNT);
    gap_inc     = gap_q + 1'b1;
    gap_d       = (rdy_i || !in_frame) ? '0 : gap_inc;
    gap_exp     = (BYTE_GAP_TICKS != 0) && in_frame && !rdy_i && (gap_inc == GAP_MAX);
    bad_end     = (state_q == ST_END) && byte_ok && (uart_i != END_BYTE);
    commit      = (state_q == ST_END) && byte_ok && (uart_i == END_BYTE);
    frame_error = in_frame && (err_i || gap_exp || bad_end);
    timer_d     = commit ? '0 : ((timer_q == TMAX) ? timer_q : timer_q + 1'b1);
  end

  // Shadow holds the payload as a bit stream; bit s of the stream is shadow[s].
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned s = 0; s < PW; s++) begin
      if (byte_cnt_q == BW'(s / 8)) shadow_d[s] = byte_in[s % 8];
    end
  end

  always_comb begin
    chan_dec = '0;
    for (int unsigned s = 0; s < PW; s++) begin
      if (LSB_FIRST) chan_dec[s] = shadow_q[s];
      else chan_dec[(s / CH_WIDTH) * CH_WIDTH + (CH_WIDTH - 1 - (s % CH_WIDTH))] = shadow_q[s];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_HUNT;
      shadow_q    <= '0;
      flags_sh_q  <= '0;
      byte_cnt_q  <= '0;
      gap_q       <= '0;
      timer_q     <= '0;
      channels_q  <= '0;
      flags_q     <= '0;
      frame_rdy_q <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      frame_rdy_q <= commit;
      frame_err_q <= frame_error;
      gap_q       <= gap_d;
      timer_q     <= timer_d;
      timeout_q   <= (timer_d >= TMAX);
      if (frame_error && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;

      if (frame_error) begin
        state_q    <= ST_HUNT;
        shadow_q   <= '0;
        byte_cnt_q <= '0;
      end else begin
        unique case (state_q)
          ST_HUNT: begin
            if (byte_ok && (uart_i == START_BYTE)) begin
              state_q    <= ST_DATA;
              shadow_q   <= '0;
              byte_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            if (byte_ok) begin
              shadow_q <= shadow_d;
              if (byte_cnt_q == LAST_B) begin
                state_q    <= ST_FLAGS;
                byte_cnt_q <= '0;
              end else begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
              end
            end
          end
          ST_FLAGS: begin
            if (byte_ok) begin
              flags_sh_q <= uart_i;
              state_q    <= ST_END;
            end
          end
          ST_END: begin
            if (commit) begin
              channels_q <= chan_dec;
              flags_q    <= flags_sh_q;
              state_q    <= ST_HUNT;
            end
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end
  end

  assign channels_o      = channels_q;
  assign flags_o         = flags_q;
  assign failsafe_o      = flags_q[3];
  assign frame_lost_o    = flags_q[2];
  assign frame_rdy_o     = frame_rdy_q;
  assign frame_err_o     = frame_err_q;
  assign frame_timeout_o = timeout_q;
  assign err_cnt_o       = err_cnt_q;

endmodule
